l2_port_arbiter: RTL and testbench
==================================

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter AddrWidth, default 48: requester address width, in bits.
REQ-002 Parameter DataWidth, default 64: data width, in bits; the byte-enable width is DataWidth/8.
REQ-003 Parameter PortBase, default 'h78000000: byte base address of the L2 port.
REQ-004 Parameter PortSize, default 'h00020000: byte size of the L2 port, a power of two.
REQ-005 Localparam MemAddrWidth = $clog2(PortSize/(DataWidth/8)), which is 14 with the defaults.
REQ-006 clk_i  in  1  the single clock.
REQ-007 rst_ni  in  1  reset, synchronous and active-low.
REQ-008 req_i  in  [1:0]  request, one bit per requester (index 0 = host, index 1 = PULP cluster).
REQ-009 addr_i  in  [1:0][AddrWidth-1:0]  byte address of each request.
REQ-010 we_i  in  [1:0]  write enable; 1 = write, 0 = read.
REQ-011 be_i  in  [1:0][DataWidth/8-1:0]  byte enables.
REQ-012 wdata_i  in  [1:0][DataWidth-1:0]  write data.
REQ-013 gnt_o  out  [1:0]  grant, combinational, in the same cycle as the request.
REQ-014 rvalid_o  out  [1:0]  response valid, driven one cycle after the grant.
REQ-015 rdata_o  out  [1:0][DataWidth-1:0]  read data.
REQ-016 err_o  out  [1:0]  response error flag, valid together with rvalid_o.
REQ-017 mem_req_o  out  1  SRAM access strobe; the SRAM always accepts.
REQ-018 mem_addr_o  out  MemAddrWidth  SRAM word index.
REQ-019 mem_we_o  out  1  SRAM write enable.
REQ-020 mem_be_o  out  DataWidth/8  SRAM byte enables.
REQ-021 mem_wdata_o  out  DataWidth  SRAM write data.
REQ-022 mem_rdata_i  in  DataWidth  SRAM read data, valid one cycle after mem_req_o.

Function
REQ-023 At most one bit of gnt_o shall be high in any cycle, and gnt_o[i] shall be high only when req_i[i] is high.
REQ-024 When exactly one requester is requesting, that requester shall be granted in the same cycle.
REQ-025 When both requesters are requesting, the requester selected by the 1-bit priority pointer prio_q shall be granted.
REQ-026 After a grant to requester i, prio_q shall become 1-i on the next cycle; with no grant, prio_q shall hold its value.
REQ-027 A requester shall hold its request fields stable until granted; the arbiter is not required to tolerate requests that change before the grant.
REQ-028 For an in-range grant, mem_req_o shall be 1 in the grant cycle, with we, be and wdata passed through from the granted requester.
REQ-029 mem_addr_o shall equal (addr - PortBase) >> $clog2(DataWidth/8), truncated to MemAddrWidth bits.
REQ-030 In cycles with no grant, mem_req_o shall be 0 and the other mem_* outputs are don't-care.
REQ-031 In the cycle after any grant to i, rvalid_o[i] shall be 1 for one cycle; this applies to reads and to writes.
REQ-032 For an in-range read, rdata_o[i] shall equal mem_rdata_i in the response cycle.
REQ-033 For a write, rdata_o[i] shall be 0 in the response cycle.
REQ-034 When rvalid_o[i] is 0, rdata_o[i] and err_o[i] shall be 0.
REQ-035 The arbiter shall allow back-to-back grants with no bubble, so a new grant can issue in the same cycle as the previous response.
REQ-036 The arbiter shall sustain one access per cycle.

Reset
REQ-037 While rst_ni is 0 at a rising clock edge, the arbiter shall set prio_q = 0, rvalid_o = 0, err_o = 0 and rdata_o = 0.
REQ-038 While rst_ni is 0, gnt_o and mem_req_o shall be 0.
REQ-039 A response pending when reset is asserted shall be discarded.

Configuration
REQ-040 When L2_ARB_RANGE_CHECK_EN is defined, a granted request whose addr is outside [PortBase, PortBase+PortSize) shall still be granted with mem_req_o held at 0.
REQ-041 Under L2_ARB_RANGE_CHECK_EN, the response to such an out-of-range request shall have err_o[i] = 1 and rdata_o[i] = 0.
REQ-042 Under L2_ARB_RANGE_CHECK_EN, an out-of-range grant shall still update the round-robin pointer.
REQ-043 When L2_ARB_RANGE_CHECK_EN is undefined, every grant shall drive mem_req_o using the truncated offset, err_o shall be tied to 0, and no comparator logic shall be present.

Verification
REQ-044 Reset, then requester 0 alone reads 'h78000008, with mem_rdata_i = 'hDEAD -> gnt_o = 01 and mem_addr_o = 1 in the same cycle; next cycle rvalid_o = 01 and rdata_o[0] = 'hDEAD.
REQ-045 Both requesters request continuously for 4 cycles after reset -> grant sequence is 0,1,0,1.
REQ-046 Requester 1 writes 'h7801FFF8 with be = 'hFF -> mem_we_o = 1 and mem_addr_o = 'h3FFF; next cycle rvalid_o[1] = 1 and err_o[1] = 0.
REQ-047 With L2_ARB_RANGE_CHECK_EN defined, requester 0 reads 'h78020000 -> gnt_o[0] = 1 and mem_req_o = 0; next cycle err_o[0] = 1 and rdata_o[0] = 0.
REQ-048 rst_ni is driven low in a cycle that contains a grant -> no rvalid_o in the following cycle, and prio_q = 0 afterwards.
REQ-049 Single requester 1 issues reads on 3 consecutive cycles -> 3 grants and 3 consecutive rvalid_o[1] pulses, with no bubble.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported L2 SRAM (host = 0, cluster = 1).
// Optional address range check is enabled by defining L2_ARB_RANGE_CHECK_EN.
module l2_port_arbiter #(
    parameter int unsigned     AddrWidth    = 48,
    parameter int unsigned     DataWidth    = 64,
    parameter longint unsigned PortBase     = 'h78000000,
    parameter longint unsigned PortSize     = 'h00020000,
    localparam int unsigned    BeWidth      = DataWidth / 8,
    localparam int unsigned    MemAddrWidth = $clog2(PortSize / (DataWidth / 8))
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [1:0]                     req_i,
    input  logic [1:0][AddrWidth-1:0]      addr_i,
    input  logic [1:0]                     we_i,
    input  logic [1:0][BeWidth-1:0]        be_i,
    input  logic [1:0][DataWidth-1:0]      wdata_i,
    output logic [1:0]                     gnt_o,
    output logic [1:0]                     rvalid_o,
    output logic [1:0][DataWidth-1:0]      rdata_o,
    output logic [1:0]                     err_o,
    output logic                           mem_req_o,
    output logic [MemAddrWidth-1:0]        mem_addr_o,
    output logic                           mem_we_o,
    output logic [BeWidth-1:0]             mem_be_o,
    output logic [DataWidth-1:0]           mem_wdata_o,
    input  logic [DataWidth-1:0]           mem_rdata_i
);

    localparam int unsigned          ByteOff  = $clog2(BeWidth);
    localparam logic [AddrWidth-1:0] BaseAddr = AddrWidth'(PortBase);

    logic                 r_prio;
    logic [1:0]           r_rvalid;
    logic                 r_we;
    logic [1:0]           w_gnt;
    logic                 w_sel;
    logic [AddrWidth-1:0] w_off;
    logic                 w_hit;
    logic                 w_rd_ok;

    // Grants are suppressed while reset is held so no access leaks to the SRAM.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_ni) begin
            if (req_i == 2'b11) begin
                w_gnt = r_prio ? 2'b10 : 2'b01;
            end else begin
                w_gnt = req_i;
            end
        end
    end

    assign gnt_o = w_gnt;
    assign w_sel = w_gnt[1];
    assign w_off = addr_i[w_sel] - BaseAddr;

`ifdef L2_ARB_RANGE_CHECK_EN
    // Addresses below the base wrap to a large offset, so one compare covers both bounds.
    assign w_hit = (w_off < AddrWidth'(PortSize));
`else
    logic w_unused_off;
    assign w_hit        = 1'b1;
    assign w_unused_off = ^{w_off[AddrWidth-1:MemAddrWidth+ByteOff], w_off[ByteOff-1:0]};
`endif

    assign mem_req_o   = (|w_gnt) & w_hit;
    assign mem_addr_o  = w_off[ByteOff +: MemAddrWidth];
    assign mem_we_o    = we_i[w_sel];
    assign mem_be_o    = be_i[w_sel];
    assign mem_wdata_o = wdata_i[w_sel];

`ifdef L2_ARB_RANGE_CHECK_EN
    logic r_err;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_prio   <= 1'b0;
            r_rvalid <= 2'b00;
            r_we     <= 1'b0;
`ifdef L2_ARB_RANGE_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_rvalid <= w_gnt;
            if (|w_gnt) begin
                r_prio <= w_gnt[0];
                r_we   <= mem_we_o;
`ifdef L2_ARB_RANGE_CHECK_EN
                r_err  <= ~w_hit;
`endif
            end
        end
    end

`ifdef L2_ARB_RANGE_CHECK_EN
    assign w_rd_ok = ~r_we & ~r_err;
    assign err_o   = r_rvalid & {2{r_err}};
`else
    assign w_rd_ok = ~r_we;
    assign err_o   = 2'b00;
`endif

    // SRAM data is forwarded straight through in the response cycle.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 2; i++) begin
            if (r_rvalid[i] && w_rd_ok) begin
                rdata_o[i] = mem_rdata_i;
            end
        end
    end

    assign rvalid_o = r_rvalid;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for reset, round-robin, back-to-back and (when L2_ARB_RANGE_CHECK_EN) range errors.
module tb_l2_port_arbiter;

    localparam logic [47:0] AB = 48'h78000008;
    localparam logic [47:0] AC = 48'h78000010;
    localparam logic [47:0] AT = 48'h7801FFF8;
    localparam logic [47:0] A0 = 48'h78000000;
    localparam logic [47:0] AO = 48'h78020000;
    localparam logic [63:0] D0 = 64'hA0;
    localparam logic [63:0] D1 = 64'hB1;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [1:0]       req;
    logic [1:0][47:0] addr;
    logic [1:0]       we;
    logic [1:0][7:0]  be;
    logic [1:0][63:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0][63:0] rdata;
    logic [1:0]       err;
    logic             mem_req;
    logic [13:0]      mem_addr;
    logic             mem_we;
    logic [7:0]       mem_be;
    logic [63:0]      mem_wdata;
    logic [63:0]      mrd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mrd)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [47:0] a0;
        logic [47:0] a1;
        logic [7:0]  be0;
        logic [7:0]  be1;
        logic [63:0] wd0;
        logic [63:0] wd1;
        logic [63:0] mrd;
        logic [1:0]  e_gnt;
        logic        e_mreq;
        logic [13:0] e_maddr;
        logic        e_mwe;
        logic [7:0]  e_mbe;
        logic [63:0] e_mwd;
        logic [1:0]  e_rv;
        logic [63:0] e_rd0;
        logic [63:0] e_rd1;
        logic [1:0]  e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [47:0] a0,
                         input logic [47:0] a1, input logic [63:0] rd);
        req     = r;
        we      = w;
        addr[0] = a0;
        addr[1] = a1;
        be[0]   = 8'h0F;
        be[1]   = 8'hF0;
        wdata[0] = D0;
        wdata[1] = D1;
        mrd     = rd;
    endtask

    task automatic do_reset();
        drive(2'b11, 2'b00, AB, AC, 64'h0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst.gnt", {62'h0, gnt}, 64'h0);
        chk("rst.mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst.rvalid", {62'h0, rvalid}, 64'h0);
        chk("rst.rdata0", rdata[0], 64'h0);
        chk("rst.rdata1", rdata[1], 64'h0);
        chk("rst.err", {62'h0, err}, 64'h0);
        @(posedge clk);
        #1;
        drive(2'b00, 2'b00, AB, AC, 64'h0);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [1:0] rr_exp[4];
        logic [1:0] b2b_req[5];
        logic [1:0] b2b_rv[5];

        vecs[0]  = '{2'b01, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h0,
                     2'b01, 1'b1, 14'h1, 1'b0, 8'h0F, D0, 2'b00, 64'h0, 64'h0, 2'b00};
        vecs[1]  = '{2'b00, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'hDEAD,
                     2'b00, 1'b0, 14'h0, 1'b0, 8'h00, 64'h0, 2'b01, 64'hDEAD, 64'h0, 2'b00};
        vecs[2]  = '{2'b11, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h0,
                     2'b10, 1'b1, 14'h2, 1'b0, 8'hF0, D1, 2'b00, 64'h0, 64'h0, 2'b00};
        vecs[3]  = '{2'b11, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h1111,
                     2'b01, 1'b1, 14'h1, 1'b0, 8'h0F, D0, 2'b10, 64'h0, 64'h1111, 2'b00};
        vecs[4]  = '{2'b11, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h2222,
                     2'b10, 1'b1, 14'h2, 1'b0, 8'hF0, D1, 2'b01, 64'h2222, 64'h0, 2'b00};
        vecs[5]  = '{2'b10, 2'b10, AB, AT, 8'h0F, 8'hFF, D0, 64'hCAFE, 64'h3333,
                     2'b10, 1'b1, 14'h3FFF, 1'b1, 8'hFF, 64'hCAFE, 2'b10, 64'h0, 64'h3333, 2'b00};
        vecs[6]  = '{2'b00, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h4444,
                     2'b00, 1'b0, 14'h0, 1'b0, 8'h00, 64'h0, 2'b10, 64'h0, 64'h0, 2'b00};
        vecs[7]  = '{2'b01, 2'b01, A0, AC, 8'h0F, 8'hF0, 64'h77, D1, 64'h0,
                     2'b01, 1'b1, 14'h0, 1'b1, 8'h0F, 64'h77, 2'b00, 64'h0, 64'h0, 2'b00};
        vecs[8]  = '{2'b00, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h5555,
                     2'b00, 1'b0, 14'h0, 1'b0, 8'h00, 64'h0, 2'b01, 64'h0, 64'h0, 2'b00};
        vecs[9]  = '{2'b10, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h0,
                     2'b10, 1'b1, 14'h2, 1'b0, 8'hF0, D1, 2'b00, 64'h0, 64'h0, 2'b00};
        vecs[10] = '{2'b11, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h6666,
                     2'b01, 1'b1, 14'h1, 1'b0, 8'h0F, D0, 2'b10, 64'h0, 64'h6666, 2'b00};
        vecs[11] = '{2'b00, 2'b00, AB, AC, 8'h0F, 8'hF0, D0, D1, 64'h7777,
                     2'b00, 1'b0, 14'h0, 1'b0, 8'h00, 64'h0, 2'b01, 64'h7777, 64'h0, 2'b00};

        rr_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};
        b2b_req = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        b2b_rv  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00};

        // Round-robin with both requesting from reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b00, AB, AC, 64'h0);
            #3;
            chk($sformatf("rr%0d.gnt", k), {62'h0, gnt}, {62'h0, rr_exp[k]});
            next_cycle();
        end

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req      = vecs[i].req;
            we       = vecs[i].we;
            addr[0]  = vecs[i].a0;
            addr[1]  = vecs[i].a1;
            be[0]    = vecs[i].be0;
            be[1]    = vecs[i].be1;
            wdata[0] = vecs[i].wd0;
            wdata[1] = vecs[i].wd1;
            mrd      = vecs[i].mrd;
            #3;
            chk($sformatf("v%0d.gnt", i), {62'h0, gnt}, {62'h0, vecs[i].e_gnt});
            chk($sformatf("v%0d.mem_req", i), {63'h0, mem_req}, {63'h0, vecs[i].e_mreq});
            if (vecs[i].e_mreq) begin
                chk($sformatf("v%0d.mem_addr", i), {50'h0, mem_addr}, {50'h0, vecs[i].e_maddr});
                chk($sformatf("v%0d.mem_we", i), {63'h0, mem_we}, {63'h0, vecs[i].e_mwe});
                chk($sformatf("v%0d.mem_be", i), {56'h0, mem_be}, {56'h0, vecs[i].e_mbe});
                chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_mwd);
            end
            chk($sformatf("v%0d.rvalid", i), {62'h0, rvalid}, {62'h0, vecs[i].e_rv});
            chk($sformatf("v%0d.rdata0", i), rdata[0], vecs[i].e_rd0);
            chk($sformatf("v%0d.rdata1", i), rdata[1], vecs[i].e_rd1);
            chk($sformatf("v%0d.err", i), {62'h0, err}, {62'h0, vecs[i].e_err});
            next_cycle();
        end

        // Reset landing on a grant cycle: response dropped, pointer back to 0
        drive(2'b01, 2'b00, AB, AC, 64'h0);
        #3;
        chk("rg.gnt_a", {62'h0, gnt}, 64'h1);
        next_cycle();
        drive(2'b01, 2'b00, AB, AC, 64'h0);
        #3;
        chk("rg.gnt_b", {62'h0, gnt}, 64'h1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rg.gnt_in_rst", {62'h0, gnt}, 64'h0);
        chk("rg.mreq_in_rst", {63'h0, mem_req}, 64'h0);
        next_cycle();
        rst_ni = 1'b1;
        drive(2'b11, 2'b00, AB, AC, 64'h99);
        #3;
        chk("rg.rvalid_after", {62'h0, rvalid}, 64'h0);
        chk("rg.gnt_prio0", {62'h0, gnt}, 64'h1);
        next_cycle();

        // Back-to-back reads from requester 1
        for (int k = 0; k < 5; k++) begin
            drive(b2b_req[k], 2'b00, AB, AC, 64'h10 + 64'(k));
            #3;
            chk($sformatf("b2b%0d.gnt", k), {62'h0, gnt}, {62'h0, b2b_req[k]});
            chk($sformatf("b2b%0d.rvalid", k), {62'h0, rvalid}, {62'h0, b2b_rv[k]});
            if (b2b_rv[k] == 2'b10) begin
                chk($sformatf("b2b%0d.rdata1", k), rdata[1], 64'h10 + 64'(k));
            end
            next_cycle();
        end

        // Out-of-range read from requester 0
        drive(2'b01, 2'b00, AO, AC, 64'h0);
        #3;
        chk("oor.gnt", {62'h0, gnt}, 64'h1);
`ifdef L2_ARB_RANGE_CHECK_EN
        chk("oor.mem_req", {63'h0, mem_req}, 64'h0);
`else
        chk("oor.mem_req", {63'h0, mem_req}, 64'h1);
        chk("oor.mem_addr", {50'h0, mem_addr}, 64'h0);
`endif
        next_cycle();
        drive(2'b00, 2'b00, AB, AC, 64'hBEEF);
        #3;
        chk("oor.rvalid", {62'h0, rvalid}, 64'h1);
`ifdef L2_ARB_RANGE_CHECK_EN
        chk("oor.err", {62'h0, err}, 64'h1);
        chk("oor.rdata0", rdata[0], 64'h0);
`else
        chk("oor.err", {62'h0, err}, 64'h0);
        chk("oor.rdata0", rdata[0], 64'hBEEF);
`endif
        next_cycle();
        #3;
        chk("oor.idle_rvalid", {62'h0, rvalid}, 64'h0);
        chk("oor.idle_err", {62'h0, err}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
